// File: rtl/exec_unit_if.sv
// Request/result bundle between issue logic and the execution unit.
// Result side connects straight to the register-bank write port.
interface exec_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  dst;
  logic        busy;
  logic        write;
  logic [31:0] wrdata;
  logic [4:0]  dr;

  modport master (
    output start, op, a, b, dst,
    input  busy, write, wrdata, dr
  );

  modport slave (
    input  start, op, a, b, dst,
    output busy, write, wrdata, dr
  );
endinterface

// File: rtl/exec_unit.sv
// Integer execution unit: single-cycle ALU ops and a
// 32-iteration shift-add multiplier.
module exec_unit (
  input  logic       clk,
  input  logic       reset,
  exec_unit_if.slave bus
);
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        accept;
  logic        last;
  logic [31:0] alu;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] acc;
  logic [31:0] acc_sum;
  logic [4:0]  cnt;
  logic [4:0]  dst_q;
  logic        write_q;
  logic [31:0] wrdata_q;
  logic [4:0]  dr_q;

  assign accept  = bus.start && (state == IDLE);
  assign last    = (cnt == 5'd31);
  assign acc_sum = acc + (mplier[0] ? mcand : 32'd0);

  assign bus.busy   = (state == MUL);
  assign bus.write  = write_q;
  assign bus.wrdata = wrdata_q;
  assign bus.dr     = dr_q;

  // Single-cycle result selection from the live operands.
  always_comb begin
    alu = 32'd0;
    unique case (bus.op)
      OP_ADD: alu = bus.a + bus.b;
      OP_SUB: alu = bus.a - bus.b;
      OP_AND: alu = bus.a & bus.b;
      OP_OR:  alu = bus.a | bus.b;
      OP_XOR: alu = bus.a ^ bus.b;
      OP_SLL: alu = bus.a << bus.b[4:0];
      OP_SRL: alu = bus.a >> bus.b[4:0];
      OP_MUL: alu = 32'd0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: enter MUL on accepted multiply, leave after 32 steps.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept && bus.op == OP_MUL) state_nxt = MUL;
      MUL:  if (last) state_nxt = IDLE;
    endcase
  end

  // Datapath: result register and multiplier iteration.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_q  <= 1'b0;
      wrdata_q <= 32'd0;
      dr_q     <= 5'd0;
      mcand    <= 32'd0;
      mplier   <= 32'd0;
      acc      <= 32'd0;
      cnt      <= 5'd0;
      dst_q    <= 5'd0;
    end else begin
      write_q <= 1'b0;
      if (accept) begin
        if (bus.op == OP_MUL) begin
          mcand  <= bus.a;
          mplier <= bus.b;
          dst_q  <= bus.dst;
          acc    <= 32'd0;
          cnt    <= 5'd0;
        end else begin
          write_q  <= 1'b1;
          wrdata_q <= alu;
          dr_q     <= bus.dst;
        end
      end else if (state == MUL) begin
        acc    <= acc_sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 5'd1;
        if (last) begin
          write_q  <= 1'b1;
          wrdata_q <= acc_sum;
          dr_q     <= dst_q;
        end
      end
    end
  end
endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: ALU ops, multiplier timing,
// dropped starts and reset abort.
module tb_exec_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vec = 0;
  int   fails = 0;

  exec_unit_if bus ();

  exec_unit dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [4:0] d);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = o;
    bus.a = x;
    bus.b = y;
    bus.dst = d;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.op = 3'd0;
    bus.a = 32'd0;
    bus.b = 32'd0;
    bus.dst = 5'd0;
    reset = 1'b1;
    tick();
    tick();
    vec++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
    vec++; if (bus.write !== 1'b0) begin fails++; $display("FAIL reset_write got %0b want 0", bus.write); end
    vec++; if (bus.wrdata !== 32'd0) begin fails++; $display("FAIL reset_wrdata got %h want 0", bus.wrdata); end
    vec++; if (bus.dr !== 5'd0) begin fails++; $display("FAIL reset_dr got %0d want 0", bus.dr); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add();
    issue(3'b000, 32'hFFFF_FFFF, 32'd2, 5'd5);
    vec++; if (bus.write !== 1'b1) begin fails++; $display("FAIL add_write got %0b want 1", bus.write); end
    vec++; if (bus.wrdata !== 32'h1) begin fails++; $display("FAIL add_data got %h want 00000001", bus.wrdata); end
    vec++; if (bus.dr !== 5'd5) begin fails++; $display("FAIL add_dr got %0d want 5", bus.dr); end
    tick();
    vec++; if (bus.write !== 1'b0) begin fails++; $display("FAIL add_write_drop got %0b want 0", bus.write); end
    vec++; if (bus.wrdata !== 32'h1 || bus.dr !== 5'd5) begin fails++; $display("FAIL add_hold got %h/%0d want 00000001/5", bus.wrdata, bus.dr); end
  endtask

  task automatic test_back_to_back();
    issue(3'b001, 32'd3, 32'd5, 5'd1);
    vec++; if (bus.write !== 1'b1 || bus.wrdata !== 32'hFFFF_FFFE || bus.dr !== 5'd1) begin
      fails++; $display("FAIL b2b_sub got w=%0b %h dr=%0d want 1 fffffffe 1", bus.write, bus.wrdata, bus.dr); end
    issue(3'b101, 32'd1, 32'h24, 5'd2);
    vec++; if (bus.write !== 1'b1 || bus.wrdata !== 32'h10 || bus.dr !== 5'd2) begin
      fails++; $display("FAIL b2b_sll got w=%0b %h dr=%0d want 1 00000010 2", bus.write, bus.wrdata, bus.dr); end
    tick();
    vec++; if (bus.write !== 1'b0) begin fails++; $display("FAIL b2b_drop got %0b want 0", bus.write); end
  endtask

  task automatic test_logic_ops();
    logic [2:0]  ops [6] = '{3'b010, 3'b011, 3'b100, 3'b110, 3'b101, 3'b000};
    logic [31:0] xa [6] = '{32'hF0F0_F0F0, 32'h0F00_0000, 32'hAAAA_AAAA,
                            32'h8000_0000, 32'h0000_0001, 32'h0000_0000};
    logic [31:0] xb [6] = '{32'hFF00_FF00, 32'h0000_00F0, 32'hFFFF_FFFF,
                            32'hFFFF_FFE1, 32'h0000_003F, 32'h0000_0000};
    logic [31:0] ex [6] = '{32'hF000_F000, 32'h0F00_00F0, 32'h5555_5555,
                            32'h4000_0000, 32'h8000_0000, 32'h0000_0000};
    logic [4:0]  dd [6] = '{5'd3, 5'd4, 5'd6, 5'd8, 5'd30, 5'd0};
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], xa[i], xb[i], dd[i]);
      vec++; if (bus.write !== 1'b1 || bus.wrdata !== ex[i] || bus.dr !== dd[i]) begin
        fails++; $display("FAIL logic_%0d got w=%0b %h dr=%0d want 1 %h %0d",
                          i, bus.write, bus.wrdata, bus.dr, ex[i], dd[i]); end
    end
    tick();
  endtask

  task automatic test_mul();
    int n;
    int busy_cnt;
    issue(3'b111, 32'h0001_0003, 32'h0002_0005, 5'd7);
    vec++; if (bus.busy !== 1'b1 || bus.write !== 1'b0) begin
      fails++; $display("FAIL mul_accept got busy=%0b w=%0b want 1 0", bus.busy, bus.write); end
    busy_cnt = 1;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      n = k;
      if (bus.write) break;
      if (bus.busy) busy_cnt++;
    end
    vec++; if (n !== 32 || bus.write !== 1'b1) begin fails++; $display("FAIL mul_latency got %0d want 32", n); end
    vec++; if (busy_cnt !== 32) begin fails++; $display("FAIL mul_busy_cycles got %0d want 32", busy_cnt); end
    vec++; if (bus.wrdata !== 32'h000B_000F || bus.dr !== 5'd7) begin
      fails++; $display("FAIL mul_result got %h dr=%0d want 000b000f 7", bus.wrdata, bus.dr); end
    tick();
    vec++; if (bus.write !== 1'b0 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL mul_after got w=%0b busy=%0b want 0 0", bus.write, bus.busy); end
  endtask

  task automatic test_ignored_start();
    int n;
    issue(3'b111, 32'd6, 32'd7, 5'd3);
    for (int k = 0; k < 4; k++) tick();
    issue(3'b000, 32'd1, 32'd1, 5'd9);
    vec++; if (bus.write !== 1'b0 || bus.busy !== 1'b1) begin
      fails++; $display("FAIL ign_start got w=%0b busy=%0b want 0 1", bus.write, bus.busy); end
    n = 5;
    for (int k = 6; k <= 40; k++) begin
      tick();
      n = k;
      if (bus.write) break;
    end
    vec++; if (n !== 32 || bus.dr !== 5'd3 || bus.wrdata !== 32'd42) begin
      fails++; $display("FAIL ign_result got n=%0d %h dr=%0d want 32 0000002a 3", n, bus.wrdata, bus.dr); end
    tick();
    vec++; if (bus.write !== 1'b0) begin fails++; $display("FAIL ign_no_late got %0b want 0", bus.write); end
  endtask

  task automatic test_reset_mid_mul();
    logic seen;
    seen = 1'b0;
    issue(3'b111, 32'h1234_5678, 32'h0000_00FF, 5'd12);
    for (int k = 0; k < 9; k++) begin
      tick();
      if (bus.write) seen = 1'b1;
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    vec++; if (bus.busy !== 1'b0 || bus.wrdata !== 32'd0 || bus.dr !== 5'd0) begin
      fails++; $display("FAIL rst_mid got busy=%0b %h dr=%0d want 0 0 0", bus.busy, bus.wrdata, bus.dr); end
    @(negedge clk);
    reset = 1'b0;
    issue(3'b000, 32'd2, 32'd2, 5'd4);
    vec++; if (bus.write !== 1'b1 || bus.wrdata !== 32'd4 || bus.dr !== 5'd4) begin
      fails++; $display("FAIL rst_add got w=%0b %h dr=%0d want 1 4 4", bus.write, bus.wrdata, bus.dr); end
    for (int k = 0; k < 30; k++) begin
      tick();
      if (bus.write) seen = 1'b1;
    end
    vec++; if (seen !== 1'b0) begin fails++; $display("FAIL rst_no_write got %0b want 0", seen); end
  endtask

  task automatic test_mul_edges();
    int n;
    issue(3'b111, 32'h0000_1234, 32'd0, 5'd10);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      n = k;
      if (bus.write) break;
    end
    vec++; if (n !== 32 || bus.wrdata !== 32'd0 || bus.dr !== 5'd10) begin
      fails++; $display("FAIL mul_zero got n=%0d %h dr=%0d want 32 0 10", n, bus.wrdata, bus.dr); end
    issue(3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      n = k;
      if (bus.write) break;
    end
    vec++; if (n !== 32 || bus.wrdata !== 32'h1 || bus.dr !== 5'd31) begin
      fails++; $display("FAIL mul_ones got n=%0d %h dr=%0d want 32 1 31", n, bus.wrdata, bus.dr); end
    vec++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL mul_done_busy got %0b want 0", bus.busy); end
    issue(3'b100, 32'h0000_FFFF, 32'h0F0F_0F0F, 5'd11);
    vec++; if (bus.write !== 1'b1 || bus.wrdata !== 32'h0F0F_F0F0 || bus.dr !== 5'd11) begin
      fails++; $display("FAIL xor_after_mul got w=%0b %h dr=%0d want 1 0f0ff0f0 11", bus.write, bus.wrdata, bus.dr); end
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_logic_ops();
    test_mul();
    test_ignored_start();
    test_reset_mid_mul();
    test_mul_edges();
    $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
    $finish;
  end
endmodule
